mux_arb_n: RTL and testbench
============================

// Module: mux_arb_n
// PURPOSE
//   N-channel, W-bit registered multiplexer with built-in arbitration. Supersedes the
//   fixed 4:1 select-line mux for datapaths where sources raise requests rather than
//   being steered by an external select.
//   Each input channel has a valid/ready handshake. Winners are chosen by fixed
//   priority or round-robin and are registered into a single output stage.
//   Sits between multiple producers and one consumer (e.g. shared bus or port).
// PARAMETERS
//   N     4   number of input channels (2..16)
//   W     8   data width per channel (bits)
//   SELW  derived localparam = $clog2(N); width of the channel index
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   mode       in   1      0 = fixed priority (lowest index wins), 1 = round-robin
//   in_valid   in   N      per-channel request; bit i belongs to channel i
//   in_ready   out  N      per-channel accept; at most one bit high per cycle
//   in_data    in   N*W    channel i data = in_data[i*W +: W]
//   out_valid  out  1      output register holds a beat
//   out_ready  in   1      consumer accepts the beat
//   out_data   out  W      registered data of the granted channel
//   out_sel    out  SELW   index of the channel that supplied out_data
// BEHAVIOUR
//   - Reset (async, immediate): out_valid=0, out_data=0, out_sel=0, rr pointer=0.
//     All in_ready are 0 while rst is high. A beat in flight is dropped.
//   - load = (~out_valid | out_ready) & |in_valid. This is combinational.
//     There is no combinational path from in_data to out_data.
//   - Grant g (combinational):
//     - mode=0: lowest i with in_valid[i].
//     - mode=1: first i with in_valid[i], searching ptr, ptr+1, ... N-1, 0, ... ptr-1.
//   - in_ready[g] = load. All other in_ready bits are 0.
//     A source transfers when in_valid[i] & in_ready[i].
//   - On load at the clock edge: out_data <= in_data[g], out_sel <= g, out_valid <= 1.
//     Latency is one cycle. Full throughput is 1 beat/clk when out_ready is held high.
//   - Drain without load (out_valid & out_ready & ~|in_valid): out_valid <= 0.
//     out_data and out_sel hold their last values.
//   - Stall (out_valid & ~out_ready): out_data and out_sel stay stable. All in_ready are 0.
//   - RR pointer: on each load, ptr <= (g == N-1) ? 0 : g+1. It wraps from N-1 to 0.
//     The pointer updates in both modes, so a switch to mode=1 starts from the last winner+1.
//   - mode may change on any cycle. The change affects arbitration in that same cycle.
//     Beats already registered are unaffected.
//   - Sources must hold in_valid and in_data stable until they transfer.
//     A request that is lowered early is simply not granted; there is no error flag.
//   - If N is not a power of two, indices >= N are never produced on out_sel.
// CONFIGURATION
//   MUX_PKT_LOCK_EN defined:
//     - Adds input in_last [N]. A lock flag and a locked index are registered.
//     - After a transfer from channel i with in_last[i]=0, the grant is locked to i.
//       Other channels get in_ready=0 even if channel i is idle.
//     - The lock releases after a transfer with in_last[i]=1. The RR pointer only
//       advances on that releasing beat.
//     - rst clears the lock.
//   MUX_PKT_LOCK_EN undefined:
//     - in_last does not exist. Every beat is arbitrated independently, as described above.
// TESTING
//   1. Hold rst=1 with all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0.
//      Release rst -> first beat is loaded on the next edge.
//   2. mode=0, N=4, in_valid=1010, data ch1=0x11, ch3=0x33, out_ready=1
//      -> out_data=0x11 and out_sel=1 every cycle; in_ready[3] is never asserted.
//   3. mode=1, all 4 valid, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 (wrap at 3).
//      One beat per clk.
//   4. out_ready=0 for 5 clks with out_valid=1 -> out_data and out_sel stay constant,
//      in_ready=0000. Set out_ready=1 -> a new beat follows next clk, with no loss or duplication.
//   5. Assert rst asynchronously mid-stream (between edges) -> out_valid falls before the next edge.
//      After release, RR restarts at channel 0.
//   6. (MUX_PKT_LOCK_EN) mode=1, ch2 sends a 3-beat packet (in_last on beat 3) while ch0 and ch3 are valid
//      -> out_sel=2,2,2 then 3, then 0.

Source files
------------

// File: rtl/mux_arb_n.sv
// mux_arb_n : N-channel, W-bit registered multiplexer with built-in arbitration.
//
// Each input channel raises a request with a valid/ready handshake. One winner
// per cycle is chosen by fixed priority (mode=0, lowest index wins) or by
// round-robin (mode=1, search starts at the rotating pointer). The winner's data
// and index are captured into a single output register stage.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous reset, active-high
//   mode       in   1       0 = fixed priority, 1 = round-robin
//   in_valid   in   N       per-channel request
//   in_ready   out  N       per-channel accept (one-hot or zero)
//   in_data    in   N*W     channel i data = in_data[i*W +: W]
//   in_last    in   N       end-of-packet marker (only with MUX_PKT_LOCK_EN)
//   out_valid  out  1       output register holds a beat
//   out_ready  in   1       consumer accepts the beat
//   out_data   out  W       registered data of the granted channel
//   out_sel    out  SELW    index of the channel that supplied out_data
//
// Configuration
//   MUX_PKT_LOCK_EN : when defined, a transfer with in_last=0 locks the grant to
//   that channel until a transfer with in_last=1 releases it. The round-robin
//   pointer only advances on the releasing beat.
module mux_arb_n #(
  parameter  int N    = 4,
  parameter  int W    = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [N*W-1:0]  in_data,
`ifdef MUX_PKT_LOCK_EN
  input  logic [N-1:0]    in_last,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [SELW-1:0] out_sel
);

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q,  out_data_d;
  logic [SELW-1:0] out_sel_q,   out_sel_d;
  logic [SELW-1:0] ptr_q,       ptr_d;

  logic [N-1:0]    req;
  logic            load;
  logic            ptr_adv;
  logic [SELW-1:0] grant, grant_fp, grant_rr;
  logic            found_fp, found_rr;
  int              idx;

`ifdef MUX_PKT_LOCK_EN
  logic            lock_q,     lock_d;
  logic [SELW-1:0] lock_idx_q, lock_idx_d;

  // While locked only the owning channel may compete; others are masked even
  // when the owner is idle, so the packet is never interleaved.
  assign req     = lock_q ? (in_valid & (N'(1) << lock_idx_q)) : in_valid;
  assign ptr_adv = load & in_last[grant];
`else
  assign req     = in_valid;
  assign ptr_adv = load;
`endif

  // Output register can take a beat when empty or being drained this cycle.
  assign load = ~rst & (~out_valid_q | out_ready) & (|req);

  always_comb begin
    grant_fp = '0;
    found_fp = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found_fp && req[i]) begin
        grant_fp = SELW'(i);
        found_fp = 1'b1;
      end
    end
  end

  // Circular search ptr, ptr+1, ... N-1, 0, ... ptr-1.
  always_comb begin
    grant_rr = '0;
    found_rr = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found_rr && req[idx]) begin
        grant_rr = SELW'(idx);
        found_rr = 1'b1;
      end
    end
  end

  assign grant    = mode ? grant_rr : grant_fp;
  assign in_ready = load ? (N'(1) << grant) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant)*W +: W];
      out_sel_d   = grant;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (ptr_adv) begin
      ptr_d = (grant == SELW'(N-1)) ? '0 : grant + 1'b1;
    end
  end

`ifdef MUX_PKT_LOCK_EN
  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (load) begin
      lock_d     = ~in_last[grant];
      lock_idx_d = grant;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_n.sv
module tb_mux_arb_n;
  localparam int N = 4;
  localparam int W = 8;
  localparam int SELW = $clog2(N);

  logic            clk;
  logic            rst;
  logic            mode;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*W-1:0]  in_data;
`ifdef MUX_PKT_LOCK_EN
  logic [N-1:0]    in_last;
`endif
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_sel;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [W-1:0] ch_data [N];

  mux_arb_n #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef MUX_PKT_LOCK_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input int sel);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sel"},   32'(out_sel),   32'(sel));
    chk({tag, "_data"},  32'(out_data),  32'(ch_data[sel]));
  endtask

  initial begin
    ch_data[0] = 8'hA0;
    ch_data[1] = 8'h11;
    ch_data[2] = 8'hC2;
    ch_data[3] = 8'h33;
    in_data    = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};
    rst        = 1'b1;
    mode       = 1'b0;
    in_valid   = 4'b1111;
    out_ready  = 1'b1;
`ifdef MUX_PKT_LOCK_EN
    in_last    = 4'b1111;
`endif

    // Reset held with every channel requesting
    tick();
    tick();
    chk("rst_in_ready",  32'(in_ready),  32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data",  32'(out_data),  32'h0);
    chk("rst_out_sel",   32'(out_sel),   32'h0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'b0001);
    tick();
    chk_beat("first", 0);                       // ptr -> 1

    // Fixed priority, channels 1 and 3 requesting
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_in_ready", 32'(in_ready), 32'b0010);
      tick();
      chk_beat("fp", 1);
    end                                         // ptr -> 2

    // Only channel 3: pointer wraps to 0
    in_valid = 4'b1000;
    #1;
    chk("wrap_in_ready", 32'(in_ready), 32'b1000);
    tick();
    chk_beat("wrap", 3);                        // ptr -> 0

    // Round-robin over all channels
    mode     = 1'b1;
    in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_beat("rr", i % 4);
    end                                         // holding ch1, ptr -> 2

    // Stall for 5 cycles
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready0", 32'(in_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_beat("stall", 1);
      chk("stall_in_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_beat("unstall", 2);                     // ptr -> 3

    // Drain with no requests
    in_valid = 4'b0000;
    tick();
    chk("drain_valid",    32'(out_valid), 32'h0);
    chk("drain_sel",      32'(out_sel),   32'h2);
    chk("drain_data",     32'(out_data),  32'hC2);
    chk("drain_in_ready", 32'(in_ready),  32'h0);

    // Mode change takes effect in the same cycle
    in_valid = 4'b1111;
    mode     = 1'b0;
    #1;
    chk("mode0_in_ready", 32'(in_ready), 32'b0001);
    mode = 1'b1;
    #1;
    chk("mode1_in_ready", 32'(in_ready), 32'b1000);
    tick();
    chk_beat("mode1", 3);                       // ptr -> 0
    tick();
    chk_beat("rr2", 0);                         // ptr -> 1
    tick();
    chk_beat("rr3", 1);                         // ptr -> 2

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_in_ready",  32'(in_ready),  32'h0);
    chk("arst_out_data",  32'(out_data),  32'h0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("rr_restart_in_ready", 32'(in_ready), 32'b0001);
    tick();
    chk_beat("rr_restart", 0);                  // ptr -> 1

`ifdef MUX_PKT_LOCK_EN
    // Packet lock: steer pointer to 2, then a 3-beat packet on channel 2
    in_valid = 4'b0010;
    in_last  = 4'b1111;
    tick();
    chk_beat("lk_setup", 1);                    // ptr -> 2
    in_valid = 4'b1101;
    in_last  = 4'b1011;
    tick();
    chk_beat("lk_b1", 2);
    #1;
    chk("lk_in_ready", 32'(in_ready), 32'b0100);
    tick();
    chk_beat("lk_b2", 2);
    in_last = 4'b1111;
    tick();
    chk_beat("lk_b3", 2);                       // released, ptr -> 3
    tick();
    chk_beat("lk_after3", 3);
    tick();
    chk_beat("lk_after0", 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
